// File: rtl/raster_frame_scheduler.sv
// raster_frame_scheduler: queues triangles, issues them to the rasterizer one
// at a time, and between frames waits for vsync, flips the display buffer and
// clears the z_buffer.
//
// Handshake (triangle input): a transfer happens on a rising clk edge where
// tri_valid && tri_ready are both 1. tri_ready depends only on queue
// occupancy, never on tri_valid. tri_data/tri_last are only looked at when
// tri_valid is 1. The rasterizer side has no ready: ru_start is held for
// START_HOLD cycles and ru_done is only taken in WAIT_DONE.
module raster_frame_scheduler #(
  parameter int          DEPTH        = 4,
  parameter int          ZB_WORDS     = 76800,
  parameter logic [5:0]  ZB_CLEAR_VAL = 6'h3F,
  parameter int          START_HOLD   = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         tri_valid,
  output logic         tri_ready,
  input  logic [287:0] tri_data,
  input  logic         tri_last,
  output logic         ru_start,
  output logic [287:0] ru_p,
  input  logic         ru_done,
  output logic         zb_sel,
  output logic         zb_we,
  output logic [16:0]  zb_addr,
  output logic [5:0]   zb_wdata,
  input  logic         vga_vs,
  output logic         buffer_select,
  output logic [15:0]  frame_count,
  output logic         busy,
  output logic [2:0]   dbg_state
);

  localparam int          AW      = $clog2(DEPTH);
  localparam int          HW      = $clog2(START_HOLD + 1);
  localparam logic [HW-1:0] HOLD  = HW'(START_HOLD);
  localparam logic [16:0] ZB_LAST = 17'(ZB_WORDS - 1);

  typedef enum logic [2:0] {
    S_CLEAR     = 3'd0,
    S_IDLE      = 3'd1,
    S_START     = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_SWAP_WAIT = 3'd4
  } state_t;

  state_t state, state_d;

  // Triangle queue: {tri_last, tri_data} entries, extra pointer bit for full
  logic [288:0]  mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          full, empty, push, pop;
  logic [288:0]  head;

  logic          last_q;
  logic          vs_q;
  logic [HW-1:0] hold_cnt;
  logic          clear_done, vs_fall;

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign tri_ready  = !full;
  assign push       = tri_valid && tri_ready;
  assign pop        = (state == S_IDLE) && !empty;
  assign head       = mem[rd_ptr[AW-1:0]];
  assign clear_done = (zb_addr == ZB_LAST);
  assign vs_fall    = vs_q && !vga_vs;

  assign zb_sel     = (state == S_CLEAR);
  assign zb_we      = (state == S_CLEAR);
  assign zb_wdata   = ZB_CLEAR_VAL;
  assign busy       = (state != S_IDLE) || !empty;
  assign dbg_state  = state;

  // Queue storage write; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {tri_last, tri_data};
  end

  // Queue pointers; reset flushes the queue
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // State register; reset lands in CLEAR so every frame starts with a clean z_buffer
  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_CLEAR;
    else          state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      S_CLEAR:     if (clear_done) state_d = S_IDLE;
      S_IDLE:      if (!empty) state_d = S_START;
      S_START:     if (hold_cnt == HOLD) state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (ru_done) state_d = last_q ? S_SWAP_WAIT : S_IDLE;
      S_SWAP_WAIT: if (vs_fall) state_d = S_CLEAR;
      default:     state_d = S_CLEAR;
    endcase
  end

  // Datapath: triangle latch, start pulse, clear address, buffer flip, vsync edge
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ru_start      <= 1'b0;
      ru_p          <= '0;
      last_q        <= 1'b0;
      hold_cnt      <= '0;
      zb_addr       <= '0;
      buffer_select <= 1'b0;
      frame_count   <= '0;
      vs_q          <= 1'b1;
    end else begin
      vs_q <= vga_vs;
      case (state)
        S_CLEAR: zb_addr <= clear_done ? 17'd0 : zb_addr + 17'd1;
        S_IDLE: begin
          if (pop) begin
            ru_p     <= head[287:0];
            last_q   <= head[288];
            hold_cnt <= '0;
          end
        end
        // First START cycle lets ru_p settle; ru_start then stays high START_HOLD cycles
        S_START: begin
          if (hold_cnt == HOLD) begin
            ru_start <= 1'b0;
          end else begin
            ru_start <= 1'b1;
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        S_WAIT_DONE: ru_start <= 1'b0;
        S_SWAP_WAIT: begin
          if (vs_fall) begin
            buffer_select <= ~buffer_select;
            frame_count   <= frame_count + 16'd1;
            zb_addr       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_raster_frame_scheduler.sv
// Directed bench for raster_frame_scheduler (DEPTH=4, ZB_WORDS=16, START_HOLD=3).
module tb_raster_frame_scheduler;

  localparam int ZBW = 16;
  localparam logic [2:0] ST_CLEAR = 3'd0, ST_IDLE = 3'd1, ST_START = 3'd2,
                         ST_WAIT = 3'd3, ST_SWAP = 3'd4;
  localparam logic [31:0] F1 = 32'h3F800000, F69 = 32'h428A0000, F169 = 32'h43290000;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         tri_valid = 1'b0;
  logic         tri_ready;
  logic [287:0] tri_data = '0;
  logic         tri_last = 1'b0;
  logic         ru_start;
  logic [287:0] ru_p;
  logic         ru_done = 1'b0;
  logic         zb_sel, zb_we;
  logic [16:0]  zb_addr;
  logic [5:0]   zb_wdata;
  logic         vga_vs = 1'b1;
  logic         buffer_select;
  logic [15:0]  frame_count;
  logic         busy;
  logic [2:0]   dbg_state;

  int checks = 0;
  int errors = 0;
  logic [288:0] exp_q[$];

  typedef struct {
    bit       valid;
    bit       done;
    bit       exp_start;
    bit       exp_busy;
    bit       exp_ready;
    bit [2:0] exp_state;
  } vec_t;
  vec_t vecs[9];

  raster_frame_scheduler #(
    .DEPTH(4), .ZB_WORDS(ZBW), .ZB_CLEAR_VAL(6'h3F), .START_HOLD(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .tri_valid(tri_valid), .tri_ready(tri_ready),
    .tri_data(tri_data), .tri_last(tri_last), .ru_start(ru_start), .ru_p(ru_p),
    .ru_done(ru_done), .zb_sel(zb_sel), .zb_we(zb_we), .zb_addr(zb_addr),
    .zb_wdata(zb_wdata), .vga_vs(vga_vs), .buffer_select(buffer_select),
    .frame_count(frame_count), .busy(busy), .dbg_state(dbg_state)
  );

  // Clock and global time limit
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [287:0] mk_tri(input logic [31:0] x1, y1, x2, y2, x3, y3);
    return {F1, y3, x3, F1, y2, x2, F1, y1, x1};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [287:0] act, input logic [287:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  // One-cycle offer; ready is sampled before the edge, accepted entries go to exp_q
  task automatic push_try(input logic [287:0] d, input logic l, output bit accepted);
    tri_valid = 1'b1;
    tri_data  = d;
    tri_last  = l;
    accepted  = tri_ready;
    step();
    tri_valid = 1'b0;
    tri_data  = '0;
    tri_last  = 1'b0;
    if (accepted) exp_q.push_back({l, d});
  endtask

  task automatic done_pulse();
    ru_done = 1'b1;
    step();
    ru_done = 1'b0;
  endtask

  // Wait for the next issue, compare ru_p with the scoreboard, measure start width
  task automatic wait_issue(input string tag);
    int guard = 0;
    int high = 0;
    logic [288:0] e;
    while (!ru_start && guard < 20) begin
      step();
      guard++;
    end
    if (!ru_start) begin
      check({tag, "_start_seen"}, 288'(ru_start), 288'(1));
    end else begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      check({tag, "_ru_p"}, ru_p, e[287:0]);
      while (ru_start && high < 20) begin
        high++;
        step();
      end
      check({tag, "_start_width"}, 288'(high), 288'(3));
    end
  endtask

  // Counts clear writes from the current CLEAR cycle onward, checking address order
  task automatic run_clear(input string tag, input int already);
    int cnt = already;
    int guard = 0;
    bit addr_ok = 1'b1;
    bit start_seen = 1'b0;
    while (zb_we && guard < 40) begin
      if (zb_addr != 17'(cnt)) addr_ok = 1'b0;
      if (ru_start) start_seen = 1'b1;
      cnt++;
      guard++;
      step();
    end
    check({tag, "_clear_writes"}, 288'(cnt), 288'(ZBW));
    check({tag, "_clear_addr_seq"}, 288'(addr_ok), 288'(1));
    check({tag, "_no_start_in_clear"}, 288'(start_seen), 288'(0));
    check({tag, "_state_idle"}, 288'(dbg_state), 288'(ST_IDLE));
    check({tag, "_zb_sel_idle"}, 288'(zb_sel), 288'(0));
  endtask

  initial begin
    logic [287:0] d1;
    logic [287:0] t[5];
    bit acc;
    int starts;

    d1 = mk_tri(F69, F69, F69, F169, F169, F69);
    for (int i = 0; i < 5; i++)
      t[i] = mk_tri(32'h41000000 + 32'(i), 32'h41100000 + 32'(i), 32'h41200000 + 32'(i),
                    32'h41300000 + 32'(i), 32'h41400000 + 32'(i), 32'h41500000 + 32'(i));

    //          valid done start busy ready state
    vecs[0] = '{1, 0, 0, 1, 1, ST_IDLE};
    vecs[1] = '{0, 0, 0, 1, 1, ST_START};
    vecs[2] = '{0, 0, 1, 1, 1, ST_START};
    vecs[3] = '{0, 0, 1, 1, 1, ST_START};
    vecs[4] = '{0, 0, 1, 1, 1, ST_START};
    vecs[5] = '{0, 0, 0, 1, 1, ST_WAIT};
    vecs[6] = '{0, 0, 0, 1, 1, ST_WAIT};
    vecs[7] = '{0, 1, 0, 0, 1, ST_IDLE};
    vecs[8] = '{0, 0, 0, 0, 1, ST_IDLE};

    // Reset and the initial 16-word clear
    do_reset();
    check("rst_ru_start", 288'(ru_start), 288'(0));
    check("rst_ru_p", ru_p, '0);
    check("rst_buffer_select", 288'(buffer_select), 288'(0));
    check("rst_frame_count", 288'(frame_count), 288'(0));
    check("rst_zb_sel", 288'(zb_sel), 288'(1));
    check("rst_busy", 288'(busy), 288'(1));
    check("rst_tri_ready", 288'(tri_ready), 288'(1));
    for (int k = 0; k < ZBW; k++) begin
      check($sformatf("clr_we_%0d", k), 288'(zb_we), 288'(1));
      check($sformatf("clr_addr_%0d", k), 288'(zb_addr), 288'(k));
      check($sformatf("clr_wdata_%0d", k), 288'(zb_wdata), 288'(6'h3F));
      step();
    end
    check("idle_zb_we", 288'(zb_we), 288'(0));
    check("idle_zb_sel", 288'(zb_sel), 288'(0));
    check("idle_busy", 288'(busy), 288'(0));
    check("idle_tri_ready", 288'(tri_ready), 288'(1));
    check("idle_zb_addr", 288'(zb_addr), 288'(0));

    // Single triangle: table-driven cycle-by-cycle, stall of 50 cycles in between
    for (int i = 0; i < 9; i++) begin
      if (i == 7) begin
        starts = 0;
        for (int c = 0; c < 50; c++) begin
          if (ru_start) starts++;
          step();
        end
        check("stall_no_start", 288'(starts), 288'(0));
        check("stall_ru_p_stable", ru_p, d1);
      end
      tri_valid = vecs[i].valid;
      tri_data  = vecs[i].valid ? d1 : '0;
      tri_last  = 1'b0;
      ru_done   = vecs[i].done;
      step();
      tri_valid = 1'b0;
      tri_data  = '0;
      ru_done   = 1'b0;
      check($sformatf("vec%0d_ru_start", i), 288'(ru_start), 288'(vecs[i].exp_start));
      check($sformatf("vec%0d_busy", i), 288'(busy), 288'(vecs[i].exp_busy));
      check($sformatf("vec%0d_tri_ready", i), 288'(tri_ready), 288'(vecs[i].exp_ready));
      check($sformatf("vec%0d_state", i), 288'(dbg_state), 288'(vecs[i].exp_state));
      if (i == 2) check("vec2_ru_p", ru_p, d1);
    end

    // Full queue: one triangle in flight, then 5 offers with the rasterizer stalled
    push_try(mk_tri(F1, F1, F1, F1, F1, F1), 1'b0, acc);
    wait_issue("lead");
    for (int i = 0; i < 4; i++) begin
      push_try(t[i], 1'b0, acc);
      check($sformatf("fill_acc_%0d", i), 288'(acc), 288'(1));
    end
    check("full_tri_ready", 288'(tri_ready), 288'(0));
    push_try(t[4], 1'b0, acc);
    check("full_5th_blocked", 288'(acc), 288'(0));
    check("full_still_waiting", 288'(dbg_state), 288'(ST_WAIT));
    done_pulse();
    wait_issue("fifo0");
    push_try(t[4], 1'b0, acc);
    check("fifo_5th_accepted", 288'(acc), 288'(1));
    for (int i = 1; i < 5; i++) begin
      done_pulse();
      wait_issue($sformatf("fifo%0d", i));
    end
    done_pulse();
    check("fifo_drained_busy", 288'(busy), 288'(0));
    check("fifo_scoreboard_empty", 288'(exp_q.size()), 288'(0));

    // Frame end with vga_vs already low: no swap until a real falling edge
    vga_vs = 1'b0;
    push_try(d1, 1'b1, acc);
    wait_issue("last");
    done_pulse();
    check("swap_state", 288'(dbg_state), 288'(ST_SWAP));
    for (int c = 0; c < 10; c++) step();
    check("swap_no_flip_low", 288'(buffer_select), 288'(0));
    check("swap_no_count_low", 288'(frame_count), 288'(0));
    check("swap_busy", 288'(busy), 288'(1));
    vga_vs = 1'b1;
    step();
    step();
    check("swap_no_flip_rise", 288'(buffer_select), 288'(0));
    check("swap_still_waiting", 288'(dbg_state), 288'(ST_SWAP));
    vga_vs = 1'b0;
    step();
    check("swap_buffer_select", 288'(buffer_select), 288'(1));
    check("swap_frame_count", 288'(frame_count), 288'(1));
    check("swap_clear_we", 288'(zb_we), 288'(1));
    check("swap_clear_addr0", 288'(zb_addr), 288'(0));

    // Triangle pushed during CLEAR waits until the clear finishes
    push_try(t[2], 1'b0, acc);
    check("clr_push_acc", 288'(acc), 288'(1));
    run_clear("frame", 1);
    step();
    check("post_clear_e1_start", 288'(ru_start), 288'(0));
    step();
    check("post_clear_e2_start", 288'(ru_start), 288'(1));
    wait_issue("post_clear");

    // Reset during WAIT_DONE with two triangles queued
    push_try(t[0], 1'b0, acc);
    push_try(t[1], 1'b0, acc);
    check("pre_rst_state", 288'(dbg_state), 288'(ST_WAIT));
    do_reset();
    exp_q.delete();
    check("mid_rst_ru_start", 288'(ru_start), 288'(0));
    check("mid_rst_buffer_select", 288'(buffer_select), 288'(0));
    check("mid_rst_frame_count", 288'(frame_count), 288'(0));
    check("mid_rst_ru_p", ru_p, '0);
    check("mid_rst_state", 288'(dbg_state), 288'(ST_CLEAR));
    check("mid_rst_addr", 288'(zb_addr), 288'(0));
    check("mid_rst_tri_ready", 288'(tri_ready), 288'(1));
    done_pulse();
    check("stray_done_state", 288'(dbg_state), 288'(ST_CLEAR));
    run_clear("mid_rst", 1);
    check("mid_rst_queue_empty", 288'(busy), 288'(0));
    starts = 0;
    for (int c = 0; c < 6; c++) begin
      if (ru_start) starts++;
      step();
    end
    check("mid_rst_no_issue", 288'(starts), 288'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/raster_frame_scheduler.md
Name: raster_frame_scheduler

Overview:
- Sequences rasterizer_unit across a whole frame.
- Queues incoming triangles and issues each one to the rasterizer with a held start pulse, then waits for done.
- After the last triangle of a frame, waits for vertical sync, flips the frame_director buffer select, and clears the z_buffer before the next frame.
- Sits between the triangle source (host/geometry stage) and the rasterizer, z_buffer write mux and frame_director.

Parameters:
- DEPTH, 4, triangle queue entries (power of two, >=2)
- ZB_WORDS, 76800, z_buffer words to clear (<=131072)
- ZB_CLEAR_VAL, 6'h3F, depth value written on clear (farthest)
- START_HOLD, 3, cycles ru_start is held high per triangle (>=1)

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- tri_valid  in  1  triangle offered
- tri_ready  out  1  queue can accept (not full)
- tri_data  in  288  {p3[2],p3[1],p3[0],p2[2],...,p1[0]}, IEEE-754 single each, p1[0] at [31:0]
- tri_last  in  1  qualifies tri_data: last triangle of frame
- ru_start  out  1  rasterizer start
- ru_p  out  288  triangle presented to rasterizer, same packing as tri_data
- ru_done  in  1  rasterizer finished current triangle
- zb_sel  out  1  1 = scheduler owns the z_buffer write port, 0 = rasterizer
- zb_we  out  1  z_buffer clear write enable
- zb_addr  out  17  z_buffer clear address
- zb_wdata  out  6  always ZB_CLEAR_VAL
- vga_vs  in  1  VGA vertical sync, active low
- buffer_select  out  1  frame_director front/back select
- frame_count  out  16  completed frames, wraps
- busy  out  1  state != IDLE or queue non-empty

Behaviour:
- Reset is synchronous, active-low, and valid mid-operation.
- Reset flushes the queue and state→CLEAR with zb_addr=0.
- Reset values: ru_start=0, ru_p=0, buffer_select=0, frame_count=0, vs_q=1.
- After the reset edge: zb_sel=1, zb_we=1, busy=1, tri_ready=1.
- Queue: FIFO of {tri_last, tri_data}; tri_ready = !full (combinational).
- Push on tri_valid&&tri_ready in any state, including CLEAR and SWAP_WAIT.
- Pop only on the IDLE→START transition. No bypass: a pushed entry is visible the cycle after the push.
- tri_data is ignored when tri_valid=0.
- States:
  - CLEAR: zb_sel=1, zb_we=1, zb_addr increments by 1 per cycle from 0. After the write at ZB_WORDS-1, go to IDLE and return zb_addr to 0. Exactly ZB_WORDS writes.
  - IDLE: zb_sel=0, zb_we=0. If the queue is non-empty, pop the head into ru_p and the last flag into last_q, then go to START.
  - START: ru_start=1 for exactly START_HOLD cycles, then go to WAIT_DONE. ru_p stays stable from pop until the next pop.
  - WAIT_DONE: ru_start=0. On ru_done=1, go to SWAP_WAIT if last_q, else go to IDLE. ru_done in any other state is ignored.
  - SWAP_WAIT: vs_q registers vga_vs each cycle. On a falling edge (vs_q=1, vga_vs=0), toggle buffer_select, increment frame_count (16-bit wrap 0xFFFF→0), set zb_addr=0, and go to CLEAR.
- A vga_vs that is already low on entry to SWAP_WAIT does not trigger; the block waits for the next falling edge.
- Latency: with the queue empty in IDLE, a handshake at edge N gives ru_start=1 from edge N+2.
- Back-to-back triangles: IDLE is visited for 1 cycle between ru_done and the next ru_start.
- ru_done coincident with a push: both are taken.
- A full queue holds tri_ready=0 until a pop. Pop and push in the same cycle from a full queue is impossible, since tri_ready=0.
- Triangles queued during SWAP_WAIT/CLEAR are held and not issued until CLEAR completes.

Test Plan:
- Reset with ZB_WORDS=16 → zb_we=1 for 16 cycles, zb_addr 0..15, zb_wdata=6'h3F, then IDLE with zb_sel=0, busy=0, tri_ready=1.
- Push one triangle (69,69,1)/(69,169,1)/(169,69,1), tri_last=0, while in IDLE → ru_start high 2 edges later for exactly 3 cycles, ru_p=pushed data. Holding ru_done=0 for 50 cycles → no further ru_start. Pulse ru_done → IDLE.
- Push 5 triangles with DEPTH=4 while the rasterizer is stalled → tri_ready=0 after 4 accepted (the 5th handshake blocked); done pulses then issue all 5 in push order.
- Last triangle done with vga_vs already 0 → no swap. Next 1→0 edge of vga_vs → buffer_select 0→1, frame_count=1, then a 16-cycle clear.
- Push a triangle during CLEAR → ru_start not asserted until CLEAR ends; ru_start rises 2 cycles after the CLEAR→IDLE transition.
- Assert reset_n=0 for 1 cycle during WAIT_DONE with 2 entries queued → queue empty, ru_start=0, buffer_select=0, frame_count=0, full clear re-runs; a stray ru_done during CLEAR is ignored.
